lights_off_solver: RTL and testbench

LIGHTS_OFF_SOLVER -- requirements
Module: lights_off_solver

---
 rtl/lights_off_solver.sv | 211 +++++++++++++++++++++
 tb/tb_lights_off_solver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lights_off_solver.sv
// ---------------------------------------------------------------------------
// lights_off_solver
//
// This module solves the one-dimensional "lights off" puzzle. Pressing
// switch k toggles cell k and its neighbours k-1 and k+1. At the edges the
// neighbour set is clipped. The solver uses light chasing:
//   - The first press (switch N-1) is a guess g.
//   - After that, switch k is pressed exactly when cell k+1 is still lit.
//     This is the only remaining way to clear cell k+1.
//   - If the guess g=0 leaves cells lit, the whole chase is repeated with
//     g=1.
//   - If g=1 also fails, the puzzle has no solution.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   puzzle[N]    light pattern to clear (bit i = cell i lit)
//   start        solve request, only honoured in IDLE
//   sol_ready    consumer accepts the result held in DONE
//   busy         high in every state except IDLE
//   sol_valid    result available, held until accepted
//   solution[N]  press vector (bit k = press switch k once)
//   press_count  popcount of solution
//   solvable     1 = solution clears puzzle, 0 = no solution exists
// ---------------------------------------------------------------------------
module lights_off_solver #(
  parameter int N = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           puzzle,
  input  logic                   start,
  input  logic                   sol_ready,
  output logic                   busy,
  output logic                   sol_valid,
  output logic [N-1:0]           solution,
  output logic [$clog2(N+1)-1:0] press_count,
  output logic                   solvable
);

  localparam int KW = $clog2(N);
  localparam int CW = $clog2(N+1);
  localparam logic [KW-1:0] K_LAST = KW'(N-1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    CHECK,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    p_q, p_d;
  logic [N-1:0]    s_q, s_d;
  logic [N-1:0]    x_q, x_d;
  logic            g_q, g_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N-1:0]    sol_q, sol_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            solvable_q, solvable_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            arm_q, arm_d;

  logic            press;
  logic [N-1:0]    mask;
  logic [N-1:0]    s_shift;

  // Cells toggled by switch k. The neighbours are clipped at both ends.
  function automatic logic [N-1:0] toggle_mask(input logic [KW-1:0] k);
    logic [N-1:0] m;
    int kk;
    kk = int'(k);
    m  = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (i == kk) || (i == kk - 1) || (i == kk + 1);
    end
    return m;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Next-state logic.
  // s_shift[k] is cell k+1, so the chase decision needs no out-of-range
  // index when k = N-1.
  // arm_q stays low for the first edge after reset. This keeps a start
  // from being taken on the edge where reset releases.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    s_d        = s_q;
    x_d        = x_q;
    g_d        = g_q;
    k_d        = k_q;
    sol_d      = sol_q;
    cnt_d      = cnt_q;
    solvable_d = solvable_q;
    arm_d      = 1'b1;
    s_shift    = s_q >> 1;
    press      = 1'b0;
    mask       = '0;

    case (state_q)
      IDLE: begin
        if (start && arm_q) begin
          p_d     = puzzle;
          state_d = LOAD;
        end
      end

      LOAD: begin
        s_d     = p_q;
        x_d     = '0;
        g_d     = 1'b0;
        k_d     = K_LAST;
        state_d = APPLY;
      end

      APPLY: begin
        press    = (k_q == K_LAST) ? g_q : s_shift[k_q];
        mask     = toggle_mask(k_q);
        x_d[k_q] = press;
        if (press) begin
          s_d = s_q ^ mask;
        end
        if (k_q == '0) begin
          state_d = CHECK;
        end else begin
          k_d = k_q - KW'(1);
        end
      end

      CHECK: begin
        if (s_q == '0) begin
          sol_d      = x_q;
          cnt_d      = popcount(x_q);
          solvable_d = 1'b1;
          state_d    = DONE;
        end else if (!g_q) begin
          s_d     = p_q;
          x_d     = '0;
          g_d     = 1'b1;
          k_d     = K_LAST;
          state_d = APPLY;
        end else begin
          sol_d      = '0;
          cnt_d      = '0;
          solvable_d = 1'b0;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (sol_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State and registered outputs. Reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      p_q        <= '0;
      s_q        <= '0;
      x_q        <= '0;
      g_q        <= 1'b0;
      k_q        <= '0;
      sol_q      <= '0;
      cnt_q      <= '0;
      solvable_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      s_q        <= s_d;
      x_q        <= x_d;
      g_q        <= g_d;
      k_q        <= k_d;
      sol_q      <= sol_d;
      cnt_q      <= cnt_d;
      solvable_q <= solvable_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      arm_q      <= arm_d;
    end
  end

  assign busy        = busy_q;
  assign sol_valid   = valid_q;
  assign solution    = sol_q;
  assign press_count = cnt_q;
  assign solvable    = solvable_q;

endmodule

// File: tb/tb_lights_off_solver.sv
// ---------------------------------------------------------------------------
// tb_lights_off_solver
//
// This bench drives two solver instances, one with N=10 and one with N=5.
// The reference solution comes from exhaustive search over every press
// vector. Each candidate's effect is computed from the neighbour-toggle
// rule.
//   - When more than one solution exists, the one that does not press
//     switch N-1 is expected.
//   - Expected latency depends on whether the top switch is pressed.
// ---------------------------------------------------------------------------
module tb_lights_off_solver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sol_ready;

  logic [9:0] puzzle10;
  logic       start10;
  logic       busy10, valid10, solv10;
  logic [9:0] sol10;
  logic [3:0] cnt10;

  logic [4:0] puzzle5;
  logic       start5;
  logic       busy5, valid5, solv5;
  logic [4:0] sol5;
  logic [2:0] cnt5;

  int tests    = 0;
  int failures = 0;
  int sel      = 10;

  logic        obs_busy, obs_valid, obs_solv;
  logic [15:0] obs_sol;
  logic [31:0] obs_cnt;

  always #5 clk = ~clk;

  lights_off_solver #(.N(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .puzzle(puzzle10), .start(start10),
    .sol_ready(sol_ready), .busy(busy10), .sol_valid(valid10),
    .solution(sol10), .press_count(cnt10), .solvable(solv10)
  );

  lights_off_solver #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .puzzle(puzzle5), .start(start5),
    .sol_ready(sol_ready), .busy(busy5), .sol_valid(valid5),
    .solution(sol5), .press_count(cnt5), .solvable(solv5)
  );

  // View of whichever instance the current step is exercising.
  always_comb begin
    if (sel == 5) begin
      obs_busy  = busy5;
      obs_valid = valid5;
      obs_solv  = solv5;
      obs_sol   = {11'b0, sol5};
      obs_cnt   = {29'b0, cnt5};
    end else begin
      obs_busy  = busy10;
      obs_valid = valid10;
      obs_solv  = solv10;
      obs_sol   = {6'b0, sol10};
      obs_cnt   = {28'b0, cnt10};
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lights toggled by applying the press vector v to n cells.
  function automatic logic [15:0] press_effect(input int n, input logic [15:0] v);
    logic [15:0] e;
    e = '0;
    for (int k = 0; k < n; k++) begin
      if (v[k]) begin
        for (int c = 0; c < n; c++) begin
          if (c >= k - 1 && c <= k + 1) e[c] = ~e[c];
        end
      end
    end
    return e;
  endfunction

  function automatic int count_ones(input logic [15:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic ref_solve(input int n, input logic [15:0] puz, output logic ok,
                           output logic [15:0] sol, output int lat);
    logic [15:0] v;
    logic        found_low;
    ok        = 1'b0;
    found_low = 1'b0;
    sol       = '0;
    for (int i = 0; i < (1 << n); i++) begin
      v = 16'(i);
      if (!found_low && press_effect(n, v) == puz) begin
        if (!v[n-1]) begin
          found_low = 1'b1;
          sol       = v;
        end else if (!ok) begin
          sol = v;
        end
        ok = 1'b1;
      end
    end
    lat = (ok && !sol[n-1]) ? n + 2 : 2 * n + 3;
  endtask

  task automatic set_start(input logic b);
    if (sel == 5) start5 = b;
    else          start10 = b;
  endtask

  task automatic set_puzzle(input logic [15:0] p);
    puzzle10 = p[9:0];
    puzzle5  = p[4:0];
  endtask

  // One complete solve and handshake on the selected instance.
  // hold  = cycles sol_ready stays low while the result is held.
  // poke  = pulse start during APPLY and again on the accept edge.
  task automatic apply_stimulus(input int n, input logic [15:0] puz, input int hold,
                                input bit poke, input string tag);
    logic        eok;
    logic [15:0] esol;
    int          elat;
    int          cyc;
    bit          got;
    ref_solve(n, puz, eok, esol, elat);
    sel = n;
    set_puzzle(puz);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    set_puzzle(16'($urandom));
    cyc = 0;
    got = 0;
    while (!got && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 4) set_start(1'b1);
      if (poke && cyc == 5) set_start(1'b0);
      if (obs_valid) got = 1;
    end
    check_output({tag, " latency"}, 32'(cyc), 32'(elat));
    check_output({tag, " solution"}, {16'b0, obs_sol}, {16'b0, esol});
    check_output({tag, " press_count"}, obs_cnt, 32'(eok ? count_ones(esol) : 0));
    check_output({tag, " solvable"}, {31'b0, obs_solv}, {31'b0, eok});
    check_output({tag, " busy_done"}, {31'b0, obs_busy}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_output({tag, " hold_valid"}, {31'b0, obs_valid}, 32'd1);
      check_output({tag, " hold_solution"}, {16'b0, obs_sol}, {16'b0, esol});
      check_output({tag, " hold_busy"}, {31'b0, obs_busy}, 32'd1);
    end
    sol_ready = 1'b1;
    if (poke) set_start(1'b1);
    @(posedge clk); #1;
    sol_ready = 1'b0;
    set_start(1'b0);
    check_output({tag, " valid_after_accept"}, {31'b0, obs_valid}, 32'd0);
    check_output({tag, " busy_after_accept"}, {31'b0, obs_busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output({tag, " idle_stays"}, {31'b0, obs_busy}, 32'd0);
    end
    check_output({tag, " idle_holds_solution"}, {16'b0, obs_sol}, {16'b0, esol});
  endtask

  initial begin
    rst_n     = 1'b0;
    sol_ready = 1'b0;
    start10   = 1'b0;
    start5    = 1'b0;
    set_puzzle('0);
    #2;
    check_output("reset busy10", {31'b0, busy10}, 32'd0);
    check_output("reset valid10", {31'b0, valid10}, 32'd0);
    check_output("reset sol10", {22'b0, sol10}, 32'd0);
    check_output("reset cnt10", {28'b0, cnt10}, 32'd0);
    check_output("reset solv10", {31'b0, solv10}, 32'd0);
    check_output("reset valid5", {31'b0, valid5}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(10, 16'b0000000000, 0, 0, "zero10");
    apply_stimulus(10, 16'b0001110000, 1, 0, "center10");
    apply_stimulus(10, 16'b0111111110, 0, 0, "allpress10");
    apply_stimulus(5, 16'b00001, 0, 0, "unsolvable5");
    apply_stimulus(5, 16'b00000, 0, 0, "zero5");
    apply_stimulus(10, 16'($urandom_range(1, 1023)), 20, 1, "hold_poke10");

    for (int r = 0; r < 10; r++) begin
      apply_stimulus(10, 16'($urandom_range(0, 1023)), int'($urandom_range(0, 3)), 0, "rand10");
    end
    for (int r = 0; r < 6; r++) begin
      apply_stimulus(5, 16'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 0, "rand5");
    end

    // Leave nonzero outputs in place, then abandon a solve part-way through.
    apply_stimulus(10, 16'b0111111110, 0, 0, "pre_reset10");
    sel = 10;
    set_puzzle(16'($urandom_range(1, 1023)));
    start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("midreset busy", {31'b0, busy10}, 32'd0);
    check_output("midreset valid", {31'b0, valid10}, 32'd0);
    check_output("midreset solution", {22'b0, sol10}, 32'd0);
    check_output("midreset press_count", {28'b0, cnt10}, 32'd0);
    check_output("midreset solvable", {31'b0, solv10}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("post_reset no_valid", {31'b0, valid10}, 32'd0);
    end
    apply_stimulus(10, 16'b1100000000, 0, 0, "after_reset10");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
